// File: rtl/contador_filtrado_param.sv
`default_nettype none
// ============================================================================
// Module      : contador_filtrado_param
// Description : Debounced push-button driving a modulo up/down counter with
//               wrap pulse and hex 7-segment decoder; CARGA_PARALELA_EN adds
//               a saturating parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_filtrado_param #(
    parameter int LARGURA       = 4,
    parameter int MODULO        = 16,
    parameter int FILTRO_CICLOS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               botao,
    input  logic               habilita,
    input  logic               sentido,
`ifdef CARGA_PARALELA_EN
    input  logic               carga,
    input  logic [LARGURA-1:0] valor_carga,
`endif
    output logic [LARGURA-1:0] S,
    output logic               estouro,
    output logic [6:0]         seg
);

    localparam int                  FILTRO_W   = (FILTRO_CICLOS > 1) ? $clog2(FILTRO_CICLOS) : 1;
    localparam logic [FILTRO_W-1:0] FILTRO_FIM = FILTRO_W'(FILTRO_CICLOS - 1);
    localparam logic [LARGURA-1:0]  CONTA_MAX  = LARGURA'(MODULO - 1);

    generate
        if (LARGURA < 1 || LARGURA > 16) begin : g_erro_largura
            $fatal(1, "contador_filtrado_param: LARGURA must be 1..16");
        end
        if (MODULO < 2 || MODULO > (1 << LARGURA)) begin : g_erro_modulo
            $fatal(1, "contador_filtrado_param: MODULO must be 2..2**LARGURA");
        end
        if (FILTRO_CICLOS < 1) begin : g_erro_filtro
            $fatal(1, "contador_filtrado_param: FILTRO_CICLOS must be >= 1");
        end
    endgenerate

    logic                sinc_1;
    logic                botao_sync;
    logic                estavel;
    logic                estavel_atraso;
    logic [FILTRO_W-1:0] filtro_cnt;
    logic                evento;
    logic [LARGURA-1:0]  prox_s;
    logic                prox_estouro;
    logic [3:0]          nibble;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_1     <= 1'b0;
            botao_sync <= 1'b0;
        end else begin
            sinc_1     <= botao;
            botao_sync <= sinc_1;
        end
    end

    // The stable value only flips after FILTRO_CICLOS consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estavel        <= 1'b0;
            estavel_atraso <= 1'b0;
            filtro_cnt     <= '0;
        end else begin
            estavel_atraso <= estavel;
            if (botao_sync == estavel) begin
                filtro_cnt <= '0;
            end else if (filtro_cnt == FILTRO_FIM) begin
                estavel    <= botao_sync;
                filtro_cnt <= '0;
            end else begin
                filtro_cnt <= filtro_cnt + 1'b1;
            end
        end
    end

    assign evento = estavel & ~estavel_atraso;

`ifdef CARGA_PARALELA_EN
    localparam logic [LARGURA:0] MODULO_EXT = (LARGURA+1)'(MODULO);
    logic [LARGURA-1:0] carga_sat;
    assign carga_sat = ({1'b0, valor_carga} >= MODULO_EXT) ? CONTA_MAX : valor_carga;
`endif

    always_comb begin
        prox_s       = S;
        prox_estouro = 1'b0;
        if (evento && habilita) begin
            if (sentido) begin
                if (S == CONTA_MAX) begin
                    prox_s       = '0;
                    prox_estouro = 1'b1;
                end else begin
                    prox_s = S + 1'b1;
                end
            end else begin
                if (S == '0) begin
                    prox_s       = CONTA_MAX;
                    prox_estouro = 1'b1;
                end else begin
                    prox_s = S - 1'b1;
                end
            end
        end
`ifdef CARGA_PARALELA_EN
        // A load overrides and swallows any same-cycle event.
        if (carga) begin
            prox_s       = carga_sat;
            prox_estouro = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            S       <= '0;
            estouro <= 1'b0;
        end else begin
            S       <= prox_s;
            estouro <= prox_estouro;
        end
    end

    generate
        if (LARGURA >= 4) begin : g_nibble_direto
            assign nibble = S[3:0];
        end else begin : g_nibble_estendido
            assign nibble = {{(4-LARGURA){1'b0}}, S};
        end
    endgenerate

    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_contador_filtrado_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_filtrado_param
// Description : Self-checking bench; default instance (MODULO=16) and a
//               MODULO=10 instance share stimulus. Honours CARGA_PARALELA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_filtrado_param;

    localparam int M_A = 16;
    localparam int M_B = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       botao;
    logic       habilita;
    logic       sentido;
`ifdef CARGA_PARALELA_EN
    logic       carga;
    logic [3:0] valor_carga;
`endif
    logic [3:0] s_a, s_b;
    logic       est_a, est_b;
    logic [6:0] seg_a, seg_b;

    int checks   = 0;
    int failures = 0;
    int exp_a    = 0;
    int exp_b    = 0;

    logic [6:0] glifo [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    always #5 clock = ~clock;

    contador_filtrado_param dut_a (
        .clock       (clock),
        .reset       (reset),
        .botao       (botao),
        .habilita    (habilita),
        .sentido     (sentido),
`ifdef CARGA_PARALELA_EN
        .carga       (carga),
        .valor_carga (valor_carga),
`endif
        .S           (s_a),
        .estouro     (est_a),
        .seg         (seg_a)
    );

    contador_filtrado_param #(.LARGURA(4), .MODULO(M_B), .FILTRO_CICLOS(4)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .botao       (botao),
        .habilita    (habilita),
        .sentido     (sentido),
`ifdef CARGA_PARALELA_EN
        .carga       (carga),
        .valor_carga (valor_carga),
`endif
        .S           (s_b),
        .estouro     (est_b),
        .seg         (seg_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit ea, input bit eb);
        chk({tag, "_S_a"},   32'(s_a),   32'(exp_a));
        chk({tag, "_est_a"}, 32'(est_a), 32'(ea));
        chk({tag, "_seg_a"}, 32'(seg_a), 32'(glifo[exp_a % 16]));
        chk({tag, "_S_b"},   32'(s_b),   32'(exp_b));
        chk({tag, "_est_b"}, 32'(est_b), 32'(eb));
        chk({tag, "_seg_b"}, 32'(seg_b), 32'(glifo[exp_b % 16]));
    endtask

    // Reference: one step around a ring of m values; wrap is landing on the seam.
    task automatic passo(input int m, input bit dir, inout int e, output bit w);
        e = (e + (dir ? 1 : m - 1)) % m;
        w = dir ? (e == 0) : (e == m - 1);
    endtask

    // Clean press: botao rises before edge 1, count must appear on edge 7.
    task automatic press(input bit hab, input bit dir, input bit late_hab, input int extra);
        bit wa, wb;
        wa = 1'b0;
        wb = 1'b0;
        habilita = hab;
        sentido  = dir;
        botao    = 1'b1;
        repeat (6) @(negedge clock);
        check_all("pre_evento", 1'b0, 1'b0);
        if (hab) begin
            passo(M_A, dir, exp_a, wa);
            passo(M_B, dir, exp_b, wb);
        end
        @(negedge clock);
        check_all("evento", wa, wb);
        if (late_hab) habilita = 1'b1;
        @(negedge clock);
        check_all("pos_evento", 1'b0, 1'b0);
        repeat (extra) @(negedge clock);
        check_all("segurado", 1'b0, 1'b0);
        botao = 1'b0;
        repeat (8) @(negedge clock);
        check_all("solto", 1'b0, 1'b0);
    endtask

    task automatic glitch(input int n);
        botao = 1'b1;
        repeat (n) @(negedge clock);
        botao = 1'b0;
        repeat (8) @(negedge clock);
        check_all("glitch", 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        botao    = 1'b0;
        habilita = 1'b1;
        sentido  = 1'b1;
`ifdef CARGA_PARALELA_EN
        carga       = 1'b0;
        valor_carga = 4'd0;
`endif
        repeat (2) @(negedge clock);
        check_all("reset", 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_all("pos_reset_inicial", 1'b0, 1'b0);

        glitch(3);
        glitch(1);

        press(1'b1, 1'b1, 1'b0, 13);
        for (int i = 0; i < 9; i++) press(1'b1, 1'b1, 1'b0, 0);

        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b1, 1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 2);
        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b1, 1'b1, 1'b0, 0);

        press(1'b0, 1'b1, 1'b1, 4);
        press(1'b1, 1'b1, 1'b0, 0);
        press(1'b1, 1'b1, 1'b0, 0);

        // Asynchronous reset in the middle of filtering a press.
        botao = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        exp_a = 0;
        exp_b = 0;
        check_all("reset_meio", 1'b0, 1'b0);
        botao = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check_all("pos_reset", 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 0);

`ifdef CARGA_PARALELA_EN
        habilita    = 1'b0;
        carga       = 1'b1;
        valor_carga = 4'd7;
        @(negedge clock);
        carga = 1'b0;
        exp_a = 7;
        exp_b = 7;
        check_all("carga_7", 1'b0, 1'b0);
        carga       = 1'b1;
        valor_carga = 4'd12;
        @(negedge clock);
        carga = 1'b0;
        exp_a = 12;
        exp_b = 9;
        check_all("carga_12", 1'b0, 1'b0);
        habilita = 1'b1;
        sentido  = 1'b1;
        botao    = 1'b1;
        repeat (6) @(negedge clock);
        check_all("carga_pre_evento", 1'b0, 1'b0);
        carga       = 1'b1;
        valor_carga = 4'd7;
        @(negedge clock);
        carga = 1'b0;
        exp_a = 7;
        exp_b = 7;
        check_all("carga_evento", 1'b0, 1'b0);
        @(negedge clock);
        check_all("carga_pos_evento", 1'b0, 1'b0);
        botao = 1'b0;
        repeat (8) @(negedge clock);
        check_all("carga_solto", 1'b0, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0)
                glitch(int'($urandom_range(1, 3)));
            else
                press($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 1'b0,
                      int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
